axis_join: RTL and testbench



---
 rtl/axis_join_pkg.sv | 14 +
 rtl/axis_join_out_reg.sv | 52 +++++
 rtl/axis_join.sv | 114 +++++++++++
 tb/tb_axis_join.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_join_pkg.sv
// Shared helpers for the axis_join lane-merge block.
package axis_join_pkg;

  // Width of one joined beat as it travels through the output skid stage:
  // {lane tusers, lane tdatas, joined tlast}.
  function automatic int unsigned join_payload_width(
    input int unsigned lanes,
    input int unsigned data_width,
    input int unsigned user_width
  );
    return lanes * (data_width + user_width) + 1;
  endfunction

endpackage

// File: rtl/axis_join_out_reg.sv
// Output register plus one-entry skid (temp) register with a registered
// internal ready, so the upstream join logic never sees m_axis_tready
// combinationally.
module axis_join_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] temp_data;
  logic             temp_valid;
  logic             in_ready_next;

  // Accept next cycle unless temp is occupied or about to be filled.
  assign in_ready_next = out_ready | (~temp_valid & (~out_valid | ~in_valid));

  // Route accepted beats to the output register or temp; refill from temp on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      temp_valid <= 1'b0;
      temp_data  <= '0;
    end else begin
      in_ready <= in_ready_next;
      if (in_valid) begin
        if (~out_valid | out_ready) begin
          out_valid <= 1'b1;
          out_data  <= in_data;
        end else begin
          temp_valid <= 1'b1;
          temp_data  <= in_data;
        end
      end else if (out_ready) begin
        out_valid  <= temp_valid;
        temp_valid <= 1'b0;
        if (temp_valid) begin
          out_data <= temp_data;
        end
      end
    end
  end

endmodule

// File: rtl/axis_join.sv
// Rejoins M_COUNT AXI4-Stream lanes into one wide beat: each lane parks one
// beat in its own slot, and once every slot is full the set is pushed into a
// registered output skid stage as a single beat.
module axis_join
  import axis_join_pkg::*;
#(
  parameter int unsigned M_COUNT     = 2,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned LAST_ENABLE = 1,
  parameter int unsigned USER_ENABLE = 1,
  parameter int unsigned USER_WIDTH  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [M_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [M_COUNT-1:0]            s_axis_tvalid,
  output logic [M_COUNT-1:0]            s_axis_tready,
  input  logic [M_COUNT-1:0]            s_axis_tlast,
  input  logic [M_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser,
  output logic                          last_mismatch
);

  localparam int unsigned DATA_BITS     = M_COUNT * DATA_WIDTH;
  localparam int unsigned USER_BITS     = M_COUNT * USER_WIDTH;
  localparam int unsigned PAYLOAD_WIDTH = join_payload_width(M_COUNT, DATA_WIDTH, USER_WIDTH);

  logic [M_COUNT-1:0]       slot_valid;
  logic [M_COUNT-1:0]       slot_last;
  logic [DATA_BITS-1:0]     slot_data;
  logic [USER_BITS-1:0]     slot_user;
  logic [M_COUNT-1:0]       load;
  logic                     en_reg;
  logic                     out_ready_reg;
  logic                     fire;
  logic                     lasts_disagree;
  logic [PAYLOAD_WIDTH-1:0] join_word;
  logic [PAYLOAD_WIDTH-1:0] out_word;

  // A join happens when every lane holds a beat and the output stage can take it.
  assign fire = (&slot_valid) & out_ready_reg;

  // Lane ready is built from registers only: empty slot, or slot emptied by this join.
  assign s_axis_tready = {M_COUNT{en_reg}} & (~slot_valid | {M_COUNT{fire}});
  assign load          = s_axis_tvalid & s_axis_tready;

  // Lane tlasts disagree when they are neither all set nor all clear.
  assign lasts_disagree = ~((&slot_last) | ~(|slot_last));

  // Per-lane holding slots; a reload in the join cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      slot_last  <= '0;
      slot_data  <= '0;
      slot_user  <= '0;
    end else begin
      for (int i = 0; i < int'(M_COUNT); i++) begin
        if (load[i]) begin
          slot_valid[i]                         <= 1'b1;
          slot_last[i]                          <= s_axis_tlast[i];
          slot_data[i*DATA_WIDTH +: DATA_WIDTH] <= s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          slot_user[i*USER_WIDTH +: USER_WIDTH] <= s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        end else if (fire) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Input enable comes up one cycle after reset and flags disagreeing tlasts.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg        <= 1'b0;
      last_mismatch <= 1'b0;
    end else begin
      en_reg        <= 1'b1;
      last_mismatch <= (LAST_ENABLE != 0) && fire && lasts_disagree;
    end
  end

  // Pack the joined beat as {tusers, tdatas, tlast}.
  always_comb begin
    join_word              = '0;
    join_word[0]           = (LAST_ENABLE != 0) ? (&slot_last) : 1'b1;
    join_word[DATA_BITS:1] = slot_data;
    if (USER_ENABLE != 0) begin
      join_word[PAYLOAD_WIDTH-1 -: USER_BITS] = slot_user;
    end
  end

  axis_join_out_reg #(
    .WIDTH (PAYLOAD_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_data   (join_word),
    .in_valid  (fire),
    .in_ready  (out_ready_reg),
    .out_data  (out_word),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  // Unpack the registered beat onto the master port.
  assign m_axis_tdata = out_word[DATA_BITS:1];
  assign m_axis_tlast = (LAST_ENABLE != 0) ? out_word[0] : 1'b1;
  assign m_axis_tuser = (USER_ENABLE != 0) ? out_word[PAYLOAD_WIDTH-1 -: USER_BITS] : '0;

endmodule

// File: tb/tb_axis_join.sv
// Self-checking bench for axis_join: directed scenarios plus a randomized run
// checked against per-lane FIFO reference queues.
module tb_axis_join;

  localparam int unsigned M  = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned UW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [M*DW-1:0] s_tdata;
  logic [M-1:0]    s_tvalid;
  logic [M-1:0]    s_tready;
  logic [M-1:0]    s_tlast;
  logic [M*UW-1:0] s_tuser;
  logic [M*DW-1:0] m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [M*UW-1:0] m_tuser;
  logic            last_mismatch;

  always #5 clk = ~clk;

  axis_join #(
    .M_COUNT     (M),
    .DATA_WIDTH  (DW),
    .LAST_ENABLE (1),
    .USER_ENABLE (1),
    .USER_WIDTH  (UW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .last_mismatch (last_mismatch)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: each lane is a FIFO of {user,last,data}; the k-th output
  // beat is the k-th beat of every lane concatenated.
  logic [9:0]  q0[$];
  logic [9:0]  q1[$];
  int          out_beats = 0;
  int          exp_mm    = 0;
  int          obs_mm    = 0;
  logic        prev_stall = 1'b0;
  logic [18:0] prev_word  = '0;

  always @(negedge clk) begin
    logic [9:0]  e0;
    logic [9:0]  e1;
    logic [18:0] exp_word;
    if (rst) begin
      q0.delete();
      q1.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(m_tvalid), 64'd1);
        check("stall_word", 64'({m_tuser, m_tlast, m_tdata}), 64'(prev_word));
      end
      if (s_tvalid[0] && s_tready[0]) q0.push_back({s_tuser[0], s_tlast[0], s_tdata[7:0]});
      if (s_tvalid[1] && s_tready[1]) q1.push_back({s_tuser[1], s_tlast[1], s_tdata[15:8]});
      if (m_tvalid && m_tready) begin
        if (q0.size() == 0 || q1.size() == 0) begin
          check("spurious_beat", 64'd1, 64'd0);
        end else begin
          e0 = q0.pop_front();
          e1 = q1.pop_front();
          exp_word = {e1[9], e0[9], e1[8] & e0[8], e1[7:0], e0[7:0]};
          check("beat", 64'({m_tuser, m_tlast, m_tdata}), 64'(exp_word));
          if (e0[8] != e1[8]) exp_mm++;
        end
        out_beats++;
      end
      if (last_mismatch) obs_mm++;
      prev_stall = m_tvalid & ~m_tready;
      prev_word  = {m_tuser, m_tlast, m_tdata};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Both lanes stream 0x01..0x10 while the sink follows a 1,0,0,1 ready pattern.
  task automatic run_backpressure();
    int          idx[M];
    int          cyc;
    int          start;
    logic [M-1:0] hs;
    logic [3:0]  pat;
    pat   = 4'b1001;
    start = out_beats;
    cyc   = 0;
    for (int i = 0; i < int'(M); i++) idx[i] = 0;
    while ((idx[0] < 16 || idx[1] < 16) && cyc < 400) begin
      for (int i = 0; i < int'(M); i++) begin
        s_tvalid[i]         = (idx[i] < 16);
        s_tdata[i*DW +: DW] = 8'(idx[i] + 1);
        s_tlast[i]          = 1'b0;
      end
      m_tready = pat[3 - (cyc % 4)];
      neg();
      hs = s_tvalid & s_tready;
      step();
      for (int i = 0; i < int'(M); i++) if (hs[i]) idx[i]++;
      cyc++;
    end
    s_tvalid = '0;
    while (out_beats - start < 16 && cyc < 500) begin
      m_tready = pat[3 - (cyc % 4)];
      step();
      cyc++;
    end
    check("bp_count", 64'(out_beats - start), 64'd16);
    m_tready = 1'b1;
    step();
  endtask

  // Random valid/ready patterns; every accepted beat is checked by the model.
  task automatic run_random(input int n_cycles);
    logic [M-1:0] hs;
    int           guard;
    hs = '0;
    for (int c = 0; c < n_cycles; c++) begin
      for (int i = 0; i < int'(M); i++) begin
        if (!s_tvalid[i] || hs[i]) begin
          s_tvalid[i]         = ($urandom_range(0, 99) < 70);
          s_tdata[i*DW +: DW] = 8'($urandom);
          s_tlast[i]          = ($urandom_range(0, 3) == 0);
          s_tuser[i]          = 1'($urandom);
        end
      end
      m_tready = ($urandom_range(0, 99) < 65);
      neg();
      hs = s_tvalid & s_tready;
      step();
    end
    s_tvalid = '0;
    m_tready = 1'b1;
    guard    = 0;
    while (q0.size() != 0 && q1.size() != 0 && guard < 50) begin
      step();
      guard++;
    end
    step();
    step();
    step();
    check("rand_drain", 64'((q0.size() != 0 && q1.size() != 0) ? 1 : 0), 64'd0);
    check("mismatch_count", 64'(obs_mm), 64'(exp_mm));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    m_tready = 1'b1;
    step();
    step();
    neg();
    check("rst_s_ready", 64'(s_tready), 64'd0);
    check("rst_m_valid", 64'(m_tvalid), 64'd0);
    check("rst_m_data", 64'(m_tdata), 64'd0);
    check("rst_m_last", 64'(m_tlast), 64'd0);
    check("rst_m_user", 64'(m_tuser), 64'd0);
    check("rst_mismatch", 64'(last_mismatch), 64'd0);

    // Ready rises one cycle after reset release.
    step();
    rst = 1'b0;
    neg();
    check("rdy_delay", 64'(s_tready), 64'd0);
    step();
    neg();
    check("rdy_up", 64'(s_tready), 64'h3);

    // Aligned lanes, back-to-back beats.
    step();
    s_tvalid = 2'b11;
    s_tdata  = 16'hA111;
    neg();
    check("al_c0_valid", 64'(m_tvalid), 64'd0);
    step();
    s_tdata = 16'hA222;
    neg();
    check("al_c1_valid", 64'(m_tvalid), 64'd0);
    step();
    s_tvalid = '0;
    neg();
    check("al_b0_valid", 64'(m_tvalid), 64'd1);
    check("al_b0_data", 64'(m_tdata), 64'hA111);
    step();
    neg();
    check("al_b1_valid", 64'(m_tvalid), 64'd1);
    check("al_b1_data", 64'(m_tdata), 64'hA222);
    step();
    neg();
    check("al_idle", 64'(m_tvalid), 64'd0);

    // Skewed lanes: lane0 waits with ready low until lane1 arrives.
    step();
    s_tvalid = 2'b01;
    s_tdata  = 16'h0005;
    step();
    s_tvalid = '0;
    for (int c = 1; c <= 3; c++) begin
      neg();
      check("skew_lane0_hold", 64'(s_tready[0]), 64'd0);
      step();
    end
    s_tvalid = 2'b10;
    s_tdata  = 16'h0600;
    neg();
    check("skew_lane0_hold", 64'(s_tready[0]), 64'd0);
    check("skew_lane1_rdy", 64'(s_tready[1]), 64'd1);
    step();
    s_tvalid = '0;
    neg();
    check("skew_c5_valid", 64'(m_tvalid), 64'd0);
    step();
    neg();
    check("skew_out_valid", 64'(m_tvalid), 64'd1);
    check("skew_out_data", 64'(m_tdata), 64'h0605);
    step();

    // tlast disagreement pulses once; agreement does not.
    s_tvalid = 2'b11;
    s_tdata  = 16'h0B0A;
    s_tlast  = 2'b01;
    step();
    s_tvalid = '0;
    s_tlast  = '0;
    neg();
    check("tl_pre", 64'(last_mismatch), 64'd0);
    step();
    neg();
    check("tl_valid", 64'(m_tvalid), 64'd1);
    check("tl_last_and", 64'(m_tlast), 64'd0);
    check("tl_pulse", 64'(last_mismatch), 64'd1);
    step();
    neg();
    check("tl_pulse_clr", 64'(last_mismatch), 64'd0);
    step();
    s_tvalid = 2'b11;
    s_tdata  = 16'h0D0C;
    s_tlast  = 2'b11;
    step();
    s_tvalid = '0;
    s_tlast  = '0;
    neg();
    check("tl2_pre", 64'(last_mismatch), 64'd0);
    step();
    neg();
    check("tl2_valid", 64'(m_tvalid), 64'd1);
    check("tl2_last", 64'(m_tlast), 64'd1);
    check("tl2_no_pulse", 64'(last_mismatch), 64'd0);
    step();
    step();

    run_backpressure();

    // Fill output, temp and slot0 under a stall, then reset for two cycles.
    m_tready = 1'b0;
    s_tvalid = 2'b11;
    s_tdata  = 16'h0101;
    step();
    s_tdata  = 16'h0202;
    step();
    s_tvalid = 2'b01;
    s_tdata  = 16'h0303;
    step();
    s_tvalid = '0;
    neg();
    check("rs_pre_ready", 64'(s_tready), 64'h2);
    check("rs_pre_valid", 64'(m_tvalid), 64'd1);
    check("rs_pre_data", 64'(m_tdata), 64'h0101);
    step();
    rst = 1'b1;
    step();
    neg();
    check("rs_valid", 64'(m_tvalid), 64'd0);
    check("rs_ready", 64'(s_tready), 64'd0);
    check("rs_data", 64'(m_tdata), 64'd0);
    check("rs_mismatch", 64'(last_mismatch), 64'd0);
    step();
    rst      = 1'b0;
    m_tready = 1'b1;
    neg();
    check("rs_rdy_lo", 64'(s_tready), 64'd0);
    check("rs_no_stale0", 64'(m_tvalid), 64'd0);
    step();
    s_tvalid = 2'b11;
    s_tdata  = 16'h3344;
    neg();
    check("rs_rdy_up", 64'(s_tready), 64'h3);
    check("rs_no_stale1", 64'(m_tvalid), 64'd0);
    step();
    s_tvalid = '0;
    neg();
    check("rs_no_stale2", 64'(m_tvalid), 64'd0);
    step();
    neg();
    check("rs_first_valid", 64'(m_tvalid), 64'd1);
    check("rs_first_data", 64'(m_tdata), 64'h3344);
    step();
    step();

    run_random(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
